a0_trace_fifo: RTL and testbench

- Sits directly downstream of the CPU top level and consumes its `a0` result output.
- Detects every change of `a0`, timestamps it with a free-running cycle counter, and buffers {value, cycle} pairs in a FIFO.
- Entries drain through a valid/ready port to the display driver or testbench, so no transient `a0` value is lost when the consumer stalls.
- Lets program output (e.g. F1 light sequence, PDF bins) be checked by value and timing without sampling `a0` every cycle.

---
 rtl/a0_trace_fifo.sv | 70 +++++++
 tb/tb_a0_trace_fifo.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/a0_trace_fifo.sv
// a0_trace_fifo: timestamps every change of a0 and buffers {value, cycle} pairs in a first-word fall-through FIFO
module a0_trace_fifo #(
    parameter int DATA_WIDTH  = 32,
    parameter int CYCLE_WIDTH = 32,
    parameter int DEPTH       = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DATA_WIDTH-1:0]     a0,
    input  logic                      cap_en,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_WIDTH-1:0]     out_data,
    output logic [CYCLE_WIDTH-1:0]    out_cycle,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      full,
    output logic                      overflow,
    output logic [15:0]               drop_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [CYCLE_WIDTH-1:0] cycle_cnt;
    logic [DATA_WIDTH-1:0]  prev_a0;
    logic [DATA_WIDTH-1:0]  data_mem [DEPTH];
    logic [CYCLE_WIDTH-1:0] cyc_mem  [DEPTH];
    logic [AW-1:0]          rd_ptr, wr_ptr;
    logic                   evt, pop, push, drop;

    // event detection and push/pop/drop decisions; a full FIFO still accepts a push when the head leaves at the same edge
    always_comb begin
        out_valid = count != '0;
        full      = count == CW'(DEPTH);
        evt       = cap_en && (a0 != prev_a0);
        pop       = out_valid && out_ready;
        push      = evt && (!full || pop);
        drop      = evt && full && !pop;
        out_data  = out_valid ? data_mem[rd_ptr] : '0;
        out_cycle = out_valid ? cyc_mem[rd_ptr] : '0;
    end

    // entry storage; no reset needed since reads are masked while empty
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            data_mem[wr_ptr] <= a0;
            cyc_mem[wr_ptr]  <= cycle_cnt;
        end
    end

    // cycle counter, change tracking, pointers, occupancy and drop bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt  <= '0;
            prev_a0    <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + CYCLE_WIDTH'(1);
            prev_a0   <= a0;
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
            if (drop) overflow <= 1'b1;
            if (drop && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
        end
    end
endmodule

// File: tb/tb_a0_trace_fifo.sv
// tb_a0_trace_fifo: directed scoreboard bench for a0_trace_fifo
module tb_a0_trace_fifo;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] a0 = '0;
    logic        cap_en = 1'b1;
    logic        out_ready = 1'b0;
    logic        out_valid, full, overflow;
    logic [31:0] out_data, out_cycle;
    logic [4:0]  count;
    logic [15:0] drop_count;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] q[$];
    logic [31:0] m_prev = '0;
    logic [31:0] m_cyc = '0;
    logic [15:0] m_drops = '0;
    logic        m_ovf = 1'b0;

    a0_trace_fifo dut (
        .clk(clk), .rst(rst), .a0(a0), .cap_en(cap_en),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_cycle(out_cycle),
        .count(count), .full(full), .overflow(overflow), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic post_check();
        chk("count", count, q.size());
        chk("out_valid", out_valid, q.size() != 0);
        chk("full", full, q.size() == 16);
        chk("overflow", overflow, m_ovf);
        chk("drop_count", drop_count, m_drops);
        chk("head_data", out_data, q.size() != 0 ? q[0][63:32] : 32'h0);
        chk("head_cycle", out_cycle, q.size() != 0 ? q[0][31:0] : 32'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        q.delete();
        m_prev = '0;
        m_cyc = '0;
        m_drops = '0;
        m_ovf = 1'b0;
        post_check();
    endtask

    task automatic step(input logic [31:0] v, input logic c, input logic r);
        logic [63:0] h;
        bit evt, pop;
        @(negedge clk);
        rst = 1'b0;
        a0 = v;
        cap_en = c;
        out_ready = r;
        evt = c && (v != m_prev);
        pop = (q.size() != 0) && r;
        if (pop) begin
            h = q.pop_front();
            chk("pop_data", out_data, h[63:32]);
            chk("pop_cycle", out_cycle, h[31:0]);
        end
        if (evt) begin
            if (q.size() < 16) q.push_back({v, m_cyc});
            else begin
                m_ovf = 1'b1;
                if (m_drops != 16'hFFFF) m_drops++;
            end
        end
        m_prev = v;
        m_cyc++;
        @(posedge clk);
        #1;
        post_check();
    endtask

    initial begin
        do_reset();
        do_reset();
        chk("rst_valid", out_valid, 1'b0);
        for (int i = 0; i < 10; i++) step(32'h0, 1'b1, 1'b0);
        chk("idle_count", count, 5'd0);

        do_reset();
        for (int i = 0; i < 3; i++) step(32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(32'h1, 1'b1, 1'b0);
        step(32'hFF, 1'b1, 1'b0);
        chk("two_count", count, 5'd2);
        chk("two_head_data", out_data, 32'h1);
        chk("two_head_cycle", out_cycle, 32'd3);
        step(32'hFF, 1'b1, 1'b1);
        chk("second_data", out_data, 32'hFF);
        chk("second_cycle", out_cycle, 32'd7);
        step(32'hFF, 1'b1, 1'b1);
        chk("drained_data", out_data, 32'h0);

        step(32'h5, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(32'h5, 1'b1, 1'b0);
        chk("masked_count", count, 5'd0);
        step(32'h6, 1'b1, 1'b0);
        chk("unmask_count", count, 5'd1);
        chk("unmask_data", out_data, 32'h6);
        step(32'h6, 1'b1, 1'b1);

        do_reset();
        for (int i = 0; i < 20; i++) begin
            step(32'd100 + 32'(i), 1'b1, 1'b0);
            chk("fill_full", full, i >= 15);
        end
        chk("ovf_set", overflow, 1'b1);
        chk("ovf_drops", drop_count, 16'd4);
        chk("ovf_head", out_data, 32'd100);

        for (int i = 0; i < 8; i++) begin
            step(32'd200 + 32'(i), 1'b1, 1'b1);
            chk("stream_count", count, 5'd16);
            chk("stream_drops", drop_count, 16'd4);
        end
        chk("stream_head", out_data, 32'd108);

        for (int i = 0; i < 9; i++) begin
            logic [31:0] prev_cyc;
            prev_cyc = out_cycle;
            step(32'd207, 1'b1, 1'b1);
            assert (out_cycle > prev_cyc) else begin
                errors++;
                $error("FAIL drain_order observed=%0h expected_above=%0h", out_cycle, prev_cyc);
            end
            checks++;
        end
        chk("pre_rst_count", count, 5'd7);
        chk("pre_rst_ovf", overflow, 1'b1);

        @(negedge clk);
        a0 = 32'h77;
        do_reset();
        chk("post_rst_count", count, 5'd0);
        chk("post_rst_valid", out_valid, 1'b0);
        chk("post_rst_ovf", overflow, 1'b0);
        chk("post_rst_drops", drop_count, 16'd0);
        step(32'h77, 1'b1, 1'b0);
        chk("post_rst_evt_data", out_data, 32'h77);
        chk("post_rst_evt_cycle", out_cycle, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
